rx_anc_acc_dump: RTL and testbench

//  Integrate-and-dump stage placed directly after the RX ancillary freq-shift/scale/clip chain.

---
 rtl/rx_anc_acc_dump_pkg.sv | 20 ++
 rtl/rx_anc_acc_lane.sv | 45 ++++
 rtl/rx_anc_acc_dump.sv | 119 +++++++++++
 tb/tb_rx_anc_acc_dump.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_anc_acc_dump_pkg.sv
// Shared constants and types for the RX ancillary integrate-and-dump stage.
// DEFAULT_LEN matches the NSIG symbol period.
package rx_anc_acc_dump_pkg;

  localparam int unsigned RX_ANC_DEFAULT_LEN = 32768;

  // Window phase, decoded from the sample counter rather than stored.
  typedef enum logic {
    ST_ACC,
    ST_LAST
  } win_state_e;

  // A full window of max-magnitude samples must fit without wrapping.
  function automatic bit acc_width_ok(input int unsigned acc_w,
                                      input int unsigned data_w,
                                      input int unsigned len_w);
    return acc_w >= data_w + len_w;
  endfunction

endpackage

// File: rtl/rx_anc_acc_lane.sv
// One signed accumulator lane: sign-extends each sample, accumulates, and on a
// dump loads acc+sample into its output register while restarting from zero.
module rx_anc_acc_lane #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add_en,
  input  logic                  dump_en,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [ACC_WIDTH-1:0]  dump_out
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] dump_q, dump_d;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] sum;

  always_comb begin
    sample_ext = {{(ACC_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
    sum        = acc_q + sample_ext;
    acc_d      = acc_q;
    dump_d     = dump_q;
    if (dump_en) begin
      dump_d = sum;
      acc_d  = '0;
    end else if (add_en) begin
      acc_d  = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dump_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dump_q <= dump_d;
    end
  end

  assign dump_out = dump_q;

endmodule

// File: rtl/rx_anc_acc_dump.sv
// Integrate-and-dump over N accepted I/Q samples; one wide I/Q sum per window
// on an AXI-stream output held in a single register.
module rx_anc_acc_dump
  import rx_anc_acc_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned DEFAULT_LEN = RX_ANC_DEFAULT_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  output logic                  in_tready,
  input  logic [LEN_WIDTH-1:0]  acc_len,
  output logic [ACC_WIDTH-1:0]  out_i,
  output logic [ACC_WIDTH-1:0]  out_q,
  output logic [LEN_WIDTH-1:0]  out_cnt,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  input  logic                  out_tready
);

  if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH, LEN_WIDTH)) begin : g_bad_acc_width
    $error("rx_anc_acc_dump: ACC_WIDTH must be >= DATA_WIDTH + LEN_WIDTH");
  end

  logic                 rst_all;
  logic [LEN_WIDTH-1:0] eff_len;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 out_tvalid_q, out_tvalid_d;
  logic                 out_tlast_q, out_tlast_d;
  win_state_e           win_state;
  logic                 closing;
  logic                 accept;
  logic                 add_en;
  logic                 dump_en;

  assign rst_all = reset || srst;
  assign eff_len = (acc_len == '0) ? LEN_WIDTH'(DEFAULT_LEN) : acc_len;

  assign win_state = (cnt_q == len_q - LEN_WIDTH'(1)) ? ST_LAST : ST_ACC;
  assign closing   = (win_state == ST_LAST) || in_tlast;
  // Only a closing sample needs the output register, so only it can stall.
  assign in_tready = !(out_tvalid_q && !out_tready && closing);
  assign accept    = in_tvalid && in_tready;
  assign add_en    = accept && !closing;
  assign dump_en   = accept && closing;

  always_comb begin
    cnt_d        = cnt_q;
    len_d        = (cnt_q == '0) ? eff_len : len_q;
    out_cnt_d    = out_cnt_q;
    out_tlast_d  = out_tlast_q;
    out_tvalid_d = out_tvalid_q && !out_tready;
    if (accept) begin
      if (closing) begin
        cnt_d        = '0;
        len_d        = eff_len;
        out_cnt_d    = cnt_q + LEN_WIDTH'(1);
        out_tlast_d  = in_tlast;
        out_tvalid_d = 1'b1;
      end else begin
        cnt_d        = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      cnt_q        <= '0;
      len_q        <= eff_len;
      out_cnt_q    <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      out_cnt_q    <= out_cnt_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
    end
  end

  rx_anc_acc_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_lane_i (
    .clk      (clk),
    .rst      (rst_all),
    .add_en   (add_en),
    .dump_en  (dump_en),
    .sample   (in_i),
    .dump_out (out_i)
  );

  rx_anc_acc_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_lane_q (
    .clk      (clk),
    .rst      (rst_all),
    .add_en   (add_en),
    .dump_en  (dump_en),
    .sample   (in_q),
    .dump_out (out_q)
  );

  assign out_cnt    = out_cnt_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tlast  = out_tlast_q;

endmodule

// File: tb/tb_rx_anc_acc_dump.sv
// Scoreboard bench for rx_anc_acc_dump: a behavioural window model pushes
// expected dumps on accept; a negedge monitor pops them on each output transfer.
module tb_rx_anc_acc_dump;

  logic        clk = 1'b0;
  logic        reset, srst;
  logic [15:0] in_i, in_q;
  logic        in_tvalid, in_tlast, in_tready;
  logic [15:0] acc_len;
  logic [31:0] out_i, out_q;
  logic [15:0] out_cnt;
  logic        out_tvalid, out_tlast, out_tready;

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic [15:0] cnt;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  longint      m_acc_i, m_acc_q;
  int unsigned m_cnt, m_len;

  rx_anc_acc_dump #(
    .DATA_WIDTH  (16),
    .LEN_WIDTH   (16),
    .ACC_WIDTH   (32),
    .DEFAULT_LEN (32768)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .srst       (srst),
    .in_i       (in_i),
    .in_q       (in_q),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .acc_len    (acc_len),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_cnt    (out_cnt),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready)
  );

  always #5 clk = ~clk;

  // Output transfer happens at the next posedge when valid&&ready at negedge.
  always @(negedge clk) begin
    if (!reset && !srst && out_tvalid && out_tready) begin
      check_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_dump: got i=%0h q=%0h cnt=%0d, required no dump", out_i, out_q, out_cnt);
      end else begin
        mon_e = sb.pop_front();
        if (out_i !== mon_e.i || out_q !== mon_e.q || out_cnt !== mon_e.cnt || out_tlast !== mon_e.last)
          $display("FAIL dump: got i=%0h q=%0h cnt=%0d last=%0b, required i=%0h q=%0h cnt=%0d last=%0b",
                   out_i, out_q, out_cnt, out_tlast, mon_e.i, mon_e.q, mon_e.cnt, mon_e.last);
        else
          pass_cnt++;
      end
    end
  end

  task automatic model_clear();
    m_acc_i = 0;
    m_acc_q = 0;
    m_cnt   = 0;
    sb.delete();
  endtask

  task automatic model_accept(input int si, input int sq, input bit last);
    exp_t e;
    if (m_cnt == 0) m_len = (acc_len == 16'd0) ? 32768 : int'(acc_len);
    m_acc_i += si;
    m_acc_q += sq;
    m_cnt++;
    if (m_cnt == m_len || last) begin
      e.i    = 32'(m_acc_i);
      e.q    = 32'(m_acc_q);
      e.cnt  = 16'(m_cnt);
      e.last = last;
      sb.push_back(e);
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
    end
  endtask

  task automatic send(input int si, input int sq, input bit last, output bit first_ready);
    int unsigned waited = 0;
    bit done = 1'b0;
    first_ready = 1'b0;
    in_i      = 16'(si);
    in_q      = 16'(sq);
    in_tlast  = last;
    in_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_tready) begin
        if (waited == 0) first_ready = 1'b1;
        model_accept(si, sq, last);
        done = 1'b1;
      end else if (++waited > 200) begin
        check_cnt++;
        $display("FAIL send_timeout: in_tready=%0b after %0d cycles, required 1", in_tready, waited);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1; srst = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0;
    in_i = '0; in_q = '0; acc_len = 16'd4; out_tready = 1'b1;
    idle(3);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_cnt++;
    if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) $display("FAIL reset_flags: got valid=%0b last=%0b, required 0 0", out_tvalid, out_tlast);
    else pass_cnt++;
    check_cnt++;
    if (out_i !== 32'd0 || out_q !== 32'd0 || out_cnt !== 16'd0) $display("FAIL reset_data: got i=%0h q=%0h cnt=%0d, required 0", out_i, out_q, out_cnt);
    else pass_cnt++;
    check_cnt++;
    if (in_tready !== 1'b1) $display("FAIL reset_tready: got %0b, required 1", in_tready);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit fr;
    for (int k = 1; k <= 8; k++) send(k, -k, 1'b0, fr);
    idle(2);
  endtask

  task automatic test_default_len();
    bit fr;
    acc_len = 16'd0;
    idle(2);
    for (int k = 0; k < 32768; k++) send(32767, -32768, 1'b0, fr);
    @(negedge clk);
    check_cnt++;
    if (out_tvalid !== 1'b1 || out_i !== 32'h3FFF8000 || out_q !== 32'hC0000000 || out_cnt !== 16'h8000)
      $display("FAIL default_len: got valid=%0b i=%0h q=%0h cnt=%0h, required 1 3fff8000 c0000000 8000",
               out_tvalid, out_i, out_q, out_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_tlast();
    bit fr;
    acc_len = 16'd8;
    idle(2);
    send(5, -5, 1'b0, fr);
    send(5, -5, 1'b0, fr);
    send(5, -5, 1'b1, fr);
    for (int k = 0; k < 8; k++) send(5, -5, 1'b0, fr);
    idle(2);
  endtask

  task automatic test_backpressure();
    bit fr;
    acc_len = 16'd2;
    idle(2);
    out_tready = 1'b0;
    send(1, -1, 1'b0, fr);
    send(2, -2, 1'b0, fr);
    send(3, -3, 1'b0, fr);
    check_cnt++;
    if (fr !== 1'b1) $display("FAIL nonclosing_accept: got first-cycle ready=%0b, required 1", fr);
    else pass_cnt++;
    in_i = 16'd4; in_q = -16'sd4; in_tlast = 1'b0; in_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_cnt++;
      if (in_tready !== 1'b0) $display("FAIL closing_stall: got in_tready=%0b, required 0", in_tready);
      else pass_cnt++;
      check_cnt++;
      if (out_tvalid !== 1'b1 || out_i !== 32'd3 || out_q !== 32'hFFFFFFFD || out_cnt !== 16'd2)
        $display("FAIL hold: got valid=%0b i=%0h q=%0h cnt=%0d, required 1 3 fffffffd 2", out_tvalid, out_i, out_q, out_cnt);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_tready = 1'b1;
    send(4, -4, 1'b0, fr);
    send(5, -5, 1'b0, fr);
    send(6, -6, 1'b0, fr);
    idle(2);
  endtask

  task automatic test_len_change();
    bit fr;
    acc_len = 16'd4;
    idle(2);
    send(1, 10, 1'b0, fr);
    send(2, 20, 1'b0, fr);
    acc_len = 16'd2;
    send(3, 30, 1'b0, fr);
    send(4, 40, 1'b0, fr);
    for (int k = 5; k <= 8; k++) send(k, 10 * k, 1'b0, fr);
    idle(2);
  endtask

  task automatic test_srst();
    bit fr;
    acc_len = 16'd4;
    idle(2);
    out_tready = 1'b0;
    for (int k = 1; k <= 7; k++) send(k, k, 1'b0, fr);
    srst = 1'b1;
    idle(1);
    srst = 1'b0;
    model_clear();
    @(negedge clk);
    check_cnt++;
    if (out_tvalid !== 1'b0 || out_i !== 32'd0) $display("FAIL srst_drop: got valid=%0b i=%0h, required 0 0", out_tvalid, out_i);
    else pass_cnt++;
    @(posedge clk); #1;
    out_tready = 1'b1;
    for (int k = 10; k <= 13; k++) send(k, -k, 1'b0, fr);
    idle(2);
  endtask

  task automatic test_drain();
    int unsigned waited = 0;
    out_tready = 1'b1;
    while (sb.size() != 0 && waited < 20) begin
      idle(1);
      waited++;
    end
    check_cnt++;
    if (sb.size() != 0) $display("FAIL drain: got %0d dumps outstanding, required 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default_len();
    test_tlast();
    test_backpressure();
    test_len_change();
    test_srst();
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
